// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR AXI4-Lite initiator and its users.
// Width macros may be overridden by the build; these are the fallbacks.
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef XLEN
`define XLEN 32
`endif

package csr_pkg;

    localparam int CSR_ADDR_WIDTH = `CSR_ADDR_WIDTH;
    localparam int CSR_DATA_WIDTH = `XLEN;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] SLVERR        = 2'b10;
    localparam logic [1:0] DECERR        = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } axil_state_e;

    typedef struct packed {
        logic                          we;
        logic [CSR_ADDR_WIDTH-1:0]     addr;
        logic [CSR_DATA_WIDTH-1:0]     wdata;
        logic [CSR_DATA_WIDTH/8-1:0]   wstrb;
    } csr_cmd_t;

endpackage

// File: rtl/axil_csr_master.sv
// AXI4-Lite initiator: turns a valid/ready command stream into single
// outstanding CSR reads/writes and returns one response beat per command.
module axil_csr_master
    import csr_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_WIDTH,
    parameter int DATA_W = CSR_DATA_WIDTH
) (
    input  logic                m00_axi_aclk,
    input  logic                m00_axi_aresetn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,

    output logic                busy,

    output logic [ADDR_W-1:0]   m00_axi_awaddr,
    output logic [2:0]          m00_axi_awprot,
    output logic                m00_axi_awvalid,
    input  logic                m00_axi_awready,

    output logic [DATA_W-1:0]   m00_axi_wdata,
    output logic [DATA_W/8-1:0] m00_axi_wstrb,
    output logic                m00_axi_wvalid,
    input  logic                m00_axi_wready,

    input  logic [1:0]          m00_axi_bresp,
    input  logic                m00_axi_bvalid,
    output logic                m00_axi_bready,

    output logic [ADDR_W-1:0]   m00_axi_araddr,
    output logic [2:0]          m00_axi_arprot,
    output logic                m00_axi_arvalid,
    input  logic                m00_axi_arready,

    input  logic [DATA_W-1:0]   m00_axi_rdata,
    input  logic [1:0]          m00_axi_rresp,
    input  logic                m00_axi_rvalid,
    output logic                m00_axi_rready
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_WR_REQ  = WR_REQ;
    localparam logic [2:0] S_WR_RESP = WR_RESP;
    localparam logic [2:0] S_RD_REQ  = RD_REQ;
    localparam logic [2:0] S_RD_DATA = RD_DATA;
    localparam logic [2:0] S_RSP     = RSP;

    logic [2:0] state;
    logic       aw_done;
    logic       w_done;
    logic       aw_fire;
    logic       w_fire;
    logic       aw_complete;
    logic       w_complete;

    // AW and W finish independently; a channel counts as complete either from
    // an earlier handshake (done flag) or from one happening this cycle.
    assign aw_fire     = m00_axi_awvalid & m00_axi_awready;
    assign w_fire      = m00_axi_wvalid & m00_axi_wready;
    assign aw_complete = aw_done | aw_fire;
    assign w_complete  = w_done | w_fire;

    assign cmd_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= S_IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wstrb   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_we          <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rsp_we    <= cmd_we;
                        rsp_rdata <= '0;
                        rsp_resp  <= AXI_RESP_OKAY;
                        if (cmd_we) begin
                            m00_axi_awaddr  <= cmd_addr;
                            m00_axi_wdata   <= cmd_wdata;
                            m00_axi_wstrb   <= cmd_wstrb;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            aw_done         <= 1'b0;
                            w_done          <= 1'b0;
                            state           <= S_WR_REQ;
                        end else begin
                            m00_axi_araddr  <= cmd_addr;
                            m00_axi_arvalid <= 1'b1;
                            state           <= S_RD_REQ;
                        end
                    end
                end

                S_WR_REQ: begin
                    if (aw_fire) begin
                        m00_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_fire) begin
                        m00_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if (aw_complete && w_complete) begin
                        m00_axi_bready <= 1'b1;
                        state          <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (m00_axi_bvalid) begin
                        m00_axi_bready <= 1'b0;
                        rsp_resp       <= m00_axi_bresp;
                        rsp_valid      <= 1'b1;
                        state          <= S_RSP;
                    end
                end

                S_RD_REQ: begin
                    if (m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (m00_axi_rvalid) begin
                        m00_axi_rready <= 1'b0;
                        rsp_rdata      <= m00_axi_rdata;
                        rsp_resp       <= m00_axi_rresp;
                        rsp_valid      <= 1'b1;
                        state          <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_csr_master.sv
// Directed bench for axil_csr_master: a small AXI4-Lite slave model with
// programmable ready delays and a scoreboard checking every response beat.
module tb_axil_csr_master;
    import csr_pkg::*;

    localparam int AW = CSR_ADDR_WIDTH;
    localparam int DW = CSR_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;

    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int checks = 0;
    int errors = 0;
    int rsp_beats = 0;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    axil_csr_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_wstrb       (cmd_wstrb),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_we          (rsp_we),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .busy            (busy),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    // Slave model: each ready rises after its valid has waited *_delay cycles;
    // a delay of 0 behaves like a ready tied high. Memory clears on reset.
    int         aw_delay = 0;
    int         w_delay = 0;
    int         ar_delay = 0;
    int         aw_cnt;
    int         w_cnt;
    int         ar_cnt;
    logic [1:0] b_code = 2'b00;
    logic [1:0] r_code = 2'b00;
    bit         b_hold = 1'b0;
    logic [DW-1:0] mem [16];
    logic          aw_got;
    logic          w_got;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          aw_have;
    logic          w_have;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    assign awready = (aw_cnt >= aw_delay);
    assign wready  = (w_cnt >= w_delay);
    assign arready = (ar_cnt >= ar_delay);
    assign aw_have = aw_got || (awvalid && awready);
    assign w_have  = w_got || (wvalid && wready);
    assign wr_addr = aw_got ? aw_addr_q : awaddr;
    assign wr_data = w_got ? w_data_q : wdata;
    assign wr_strb = w_got ? w_strb_q : wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (awvalid) begin
                if (awready) begin aw_got <= 1'b1; aw_addr_q <= awaddr; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid) begin
                if (wready) begin w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (arvalid) begin
                if (arready) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[araddr[5:2]];
                    rresp  <= r_code;
                    ar_cnt <= 0;
                end else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (aw_have && w_have && !bvalid && !b_hold) begin
                for (int b = 0; b < SW; b++)
                    if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
                bvalid <= 1'b1;
                bresp  <= b_code;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per accepted response beat and checks that
    // a stalled response keeps its payload steady.
    logic          held_valid = 1'b0;
    logic          held_we;
    logic [DW-1:0] held_rdata;
    logic [1:0]    held_resp;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_valid = 1'b0;
        end else if (rsp_valid) begin
            if (held_valid) begin
                check_output("rsp_hold_we", 64'(rsp_we), 64'(held_we));
                check_output("rsp_hold_rdata", 64'(rsp_rdata), 64'(held_rdata));
                check_output("rsp_hold_resp", 64'(rsp_resp), 64'(held_resp));
            end
            if (rsp_ready) begin
                rsp_beats++;
                held_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got beat we=%0b rdata=0x%0h, expected none", rsp_we, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check_output("rsp_we", 64'(rsp_we), 64'(e.we));
                    check_output("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check_output("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                end
            end else begin
                held_valid = 1'b1;
                held_we    = rsp_we;
                held_rdata = rsp_rdata;
                held_resp  = rsp_resp;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic apply_stimulus(input csr_cmd_t c, input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp);
        bit accepted = 1'b0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_we    = c.we;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_wstrb = c.wstrb;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin accepted = 1'b1; break; end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept: got cmd_ready=0 for 50 cycles, expected acceptance");
        end else begin
            e.we = c.we; e.rdata = exp_rdata; e.resp = exp_resp;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got busy=1 after 100 cycles, expected idle", name);
        end
        @(posedge clk); #1;
    endtask

    function automatic csr_cmd_t mk(input logic we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input logic [SW-1:0] s);
        csr_cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.wstrb = s;
        return c;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats0;
        bit seen;

        // Reset values
        @(negedge clk);
        check_output("rst_awvalid", 64'(awvalid), 0);
        check_output("rst_wvalid", 64'(wvalid), 0);
        check_output("rst_arvalid", 64'(arvalid), 0);
        check_output("rst_bready", 64'(bready), 0);
        check_output("rst_rready", 64'(rready), 0);
        check_output("rst_rsp_valid", 64'(rsp_valid), 0);
        check_output("rst_awaddr", 64'(awaddr), 0);
        check_output("rst_rsp_rdata", 64'(rsp_rdata), 0);
        check_output("rst_busy", 64'(busy), 0);
        check_output("rst_cmd_ready", 64'(cmd_ready), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] write 0xDEADBEEF to 0x08, readies high");
        apply_stimulus(mk(1'b1, AW'('h08), 32'hDEADBEEF, 4'hF), '0, AXI_RESP_OKAY);
        @(negedge clk);
        check_output("wr_c1_awvalid", 64'(awvalid), 1);
        check_output("wr_c1_wvalid", 64'(wvalid), 1);
        check_output("wr_c1_awaddr", 64'(awaddr), 64'h08);
        check_output("wr_c1_wdata", 64'(wdata), 64'hDEADBEEF);
        check_output("wr_c1_wstrb", 64'(wstrb), 64'hF);
        check_output("wr_c1_bready", 64'(bready), 0);
        check_output("wr_c1_prot", 64'({awprot, arprot}), 0);
        check_output("wr_c1_busy", 64'(busy), 1);
        @(negedge clk);
        check_output("wr_c2_awvalid", 64'(awvalid), 0);
        check_output("wr_c2_wvalid", 64'(wvalid), 0);
        check_output("wr_c2_bready", 64'(bready), 1);
        check_output("wr_c2_rsp_valid", 64'(rsp_valid), 0);
        @(negedge clk);
        check_output("wr_c3_rsp_valid", 64'(rsp_valid), 1);
        check_output("wr_c3_bready", 64'(bready), 0);
        wait_done("wr1");

        $display("[TB] read back 0x08");
        beats0 = rsp_beats;
        apply_stimulus(mk(1'b0, AW'('h08), '0, '0), 32'hDEADBEEF, AXI_RESP_OKAY);
        @(negedge clk);
        check_output("rd_c1_arvalid", 64'(arvalid), 1);
        check_output("rd_c1_araddr", 64'(araddr), 64'h08);
        check_output("rd_c1_rready", 64'(rready), 0);
        @(negedge clk);
        check_output("rd_c2_arvalid", 64'(arvalid), 0);
        check_output("rd_c2_rready", 64'(rready), 1);
        @(negedge clk);
        check_output("rd_c3_rsp_valid", 64'(rsp_valid), 1);
        wait_done("rd1");
        check_output("rd_beat_count", 64'(rsp_beats - beats0), 1);

        $display("[TB] write with wready 3 cycles before awready, partial strobes");
        aw_delay = 3;
        apply_stimulus(mk(1'b1, AW'('h10), 32'h12345678, 4'b0011), '0, AXI_RESP_OKAY);
        @(negedge clk);
        check_output("skew_c1_both", 64'({awvalid, wvalid, bready}), 64'b110);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check_output("skew_wvalid_dropped", 64'(wvalid), 0);
            check_output("skew_awvalid_held", 64'(awvalid), 1);
            check_output("skew_awaddr_stable", 64'(awaddr), 64'h10);
            check_output("skew_bready_early", 64'(bready), 0);
        end
        @(negedge clk);
        check_output("skew_c5_awvalid", 64'(awvalid), 0);
        check_output("skew_c5_bready", 64'(bready), 1);
        wait_done("skew");
        aw_delay = 0;
        // Only the low two bytes of an all-zero word were written.
        apply_stimulus(mk(1'b0, AW'('h10), '0, '0), 32'h00005678, AXI_RESP_OKAY);
        wait_done("rd_partial");

        $display("[TB] read 0x3C with delayed arready and SLVERR");
        apply_stimulus(mk(1'b1, AW'('h3C), 32'hCAFEF00D, 4'hF), '0, AXI_RESP_OKAY);
        wait_done("wr_3c");
        ar_delay = 5;
        r_code   = SLVERR;
        apply_stimulus(mk(1'b0, AW'('h3C), '0, '0), 32'hCAFEF00D, SLVERR);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_output("ar_delay_arvalid", 64'(arvalid), 1);
            check_output("ar_delay_araddr", 64'(araddr), 64'h3C);
            check_output("ar_delay_rready", 64'(rready), 0);
        end
        @(negedge clk);
        check_output("ar_done_arvalid", 64'(arvalid), 0);
        check_output("ar_done_rready", 64'(rready), 1);
        wait_done("rd_slverr");
        ar_delay = 0;
        r_code   = AXI_RESP_OKAY;

        $display("[TB] write returning DECERR");
        b_code = DECERR;
        apply_stimulus(mk(1'b1, AW'('h20), 32'h0BADF00D, 4'hF), '0, DECERR);
        wait_done("wr_decerr");
        b_code = AXI_RESP_OKAY;

        $display("[TB] stall rsp_ready with next command pending");
        rsp_ready = 1'b0;
        apply_stimulus(mk(1'b1 ^ 1'b1, AW'('h08), '0, '0), 32'hDEADBEEF, AXI_RESP_OKAY);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = AW'('h04);
        cmd_wdata = 32'hA5A5A5A5;
        cmd_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check_output("stall_rsp_seen", 64'(seen), 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_output("stall_cmd_ready", 64'(cmd_ready), 0);
            check_output("stall_rsp_valid", 64'(rsp_valid), 1);
            check_output("stall_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("stall_h_cmd_ready", 64'(cmd_ready), 0);
        @(negedge clk);
        check_output("stall_next_accept", 64'(cmd_ready), 1);
        begin
            exp_t e;
            e.we = 1'b1; e.rdata = '0; e.resp = AXI_RESP_OKAY;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("stall_wr");

        $display("[TB] reset asserted in WR_RESP");
        b_hold = 1'b1;
        apply_stimulus(mk(1'b1, AW'('h00), 32'h11111111, 4'hF), '0, AXI_RESP_OKAY);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bready) begin seen = 1'b1; break; end
        end
        check_output("rst_mid_in_wr_resp", 64'(seen), 1);
        check_output("rst_mid_busy_before", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_awvalid", 64'(awvalid), 0);
        check_output("rst_mid_wvalid", 64'(wvalid), 0);
        check_output("rst_mid_bready", 64'(bready), 0);
        check_output("rst_mid_rsp_valid", 64'(rsp_valid), 0);
        check_output("rst_mid_busy", 64'(busy), 0);
        check_output("rst_mid_cmd_ready", 64'(cmd_ready), 1);
        check_output("rst_mid_awaddr", 64'(awaddr), 0);
        exp_q.delete();
        @(posedge clk); #1;
        b_hold = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // The slave memory was cleared by the same reset.
        apply_stimulus(mk(1'b0, AW'('h00), '0, '0), '0, AXI_RESP_OKAY);
        wait_done("rd_after_rst");

        check_output("scoreboard_drain", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_csr_master.md
Name: axil_csr_master

Overview:
- AXI4-Lite initiator that drives the accelerator's CSR slave port (the s00_axi responder) from a simple valid/ready command stream.
- Used by the on-chip control sequencer and by the integration bench to issue register writes and reads.
- Allows one outstanding transaction at a time.
- Each completed transaction returns exactly one response beat carrying read data and the AXI response code.

Parameters:
- ADDR_W, `CSR_ADDR_WIDTH, CSR byte-address width.
- DATA_W, `XLEN, data width; DATA_W/8 strobe bits.

Ports:
- m00_axi_aclk  input  1  clock
- m00_axi_aresetn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_we  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  byte address
- cmd_wdata  input  DATA_W  write data (ignored for reads)
- cmd_wstrb  input  DATA_W/8  write strobes (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_we  output  1  echo of cmd_we
- rsp_rdata  output  DATA_W  read data; 0 for writes
- rsp_resp  output  2  BRESP or RRESP
- busy  output  1  high in any state except IDLE
- m00_axi_awaddr/awprot/awvalid/awready: out ADDR_W / out 3 / out 1 / in 1
- m00_axi_wdata/wstrb/wvalid/wready: out DATA_W / out DATA_W/8 / out 1 / in 1
- m00_axi_bresp/bvalid/bready: in 2 / in 1 / out 1
- m00_axi_araddr/arprot/arvalid/arready: out ADDR_W / out 3 / out 1 / in 1
- m00_axi_rdata/rresp/rvalid/rready: in DATA_W / in 2 / in 1 / out 1

Behaviour:
- All outputs are registered, except cmd_ready (= state==IDLE) and busy (= state!=IDLE).
- Reset values: all valids and readies 0, addr/data/strb/rdata/resp 0, state IDLE.
- awprot and arprot are constant 3'b000.
- State IDLE:
  - On cmd_valid, latch the command.
  - Write: go to WR_REQ, assert awvalid and wvalid next cycle.
  - Read: go to RD_REQ, assert arvalid next cycle.
- State WR_REQ:
  - awvalid drops the cycle after awready is seen; wvalid drops the cycle after wready is seen. The two are tracked independently and may complete in any order or in the same cycle.
  - When both have completed, go to WR_RESP and assert bready.
  - bready is never high before both AW and W have handshaken.
- State WR_RESP: on bvalid && bready, capture bresp, drop bready, go to RSP.
- State RD_REQ: on arready, drop arvalid, go to RD_DATA and assert rready.
- State RD_DATA: on rvalid && rready, capture rdata and rresp, drop rready, go to RSP.
- State RSP:
  - rsp_valid is high; hold all rsp_* stable until rsp_ready.
  - Then go to IDLE.
- Valid stability: once asserted, no AXI valid deasserts and no address/data/strobe changes until its handshake. AXI ready inputs may be asserted before the corresponding valid.
- Latency, slaves with readies tied high:
  - Write: cmd accept cycle 0, AW/W valid cycle 1, bvalid seen cycle 2, rsp_valid cycle 3.
  - Read: cmd accept cycle 0, arvalid cycle 1, rvalid seen cycle 2, rsp_valid cycle 3.
  - Back-to-back throughput: one transaction per 4 cycles with rsp_ready tied high (RSP to IDLE costs one cycle).
- Response codes: SLVERR/DECERR are passed through unmodified in rsp_resp. No retry.
- Response arriving early: bvalid or rvalid asserted before the master is ready is left pending (bready/rready low) and is not lost.
- Reset mid-transaction: all outputs return immediately to reset values. The in-flight transaction is abandoned; the bench/system resets the slave together.

Decomposition:
- Shared package, csr_pkg:
  - typedef enum axil_state_e {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP}
  - localparams AXI_RESP_OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11
  - packed struct csr_cmd_t {we, addr, wdata, wstrb}
- No sub-module is needed; a single FSM with two done-flags (aw_done, w_done) covers it.

Test Plan:
- Write 0xDEADBEEF to 0x08, wstrb=4'hF, slave readies high → AW/W handshake in cycle 1, bready cycle 2, rsp_valid cycle 3 with rsp_resp=00, rsp_rdata=0.
- Read 0x08 after that write; slave returns rdata=0xDEADBEEF, rresp=00 → rsp_rdata=0xDEADBEEF, rsp_we=0, exactly one rsp beat.
- Write where slave asserts wready 3 cycles before awready → wvalid drops after its handshake, awvalid held with stable awaddr, bready only after both handshakes, rsp_resp=00.
- Read 0x3C with slave returning rresp=2'b10 and arready delayed 5 cycles → arvalid held 5 cycles, rsp_resp=10, rsp_rdata=slave data.
- Hold rsp_ready low 4 cycles with cmd_valid pending → cmd_ready stays 0 and rsp_* stay stable; next command is accepted the cycle after rsp_ready.
- Assert m00_axi_aresetn low while in WR_RESP → awvalid/wvalid/bready/rsp_valid go 0 without waiting for a clock edge, busy=0; after release a read to 0x00 completes normally.
